// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU datapath: opcodes, instruction field
// positions and default widths.
package alu_pkg;

   localparam int unsigned DATA_W_DEFAULT = 8;
   localparam int unsigned REG_AW_DEFAULT = 3;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SHL  = 4'd5;
   localparam logic [3:0] OP_SHR  = 4'd6;
   localparam logic [3:0] OP_NOT  = 4'd7;
   localparam logic [3:0] OP_MUL  = 4'd8;
   localparam logic [3:0] OP_DIV  = 4'd9;
   localparam logic [3:0] OP_LAST = 4'd9;

   localparam int unsigned INSTR_W = 16;
   localparam int unsigned OPC_W   = 4;
   localparam int unsigned OPC_LSB = 12;
   localparam int unsigned RD_LSB  = 9;
   localparam int unsigned RS1_LSB = 6;
   localparam int unsigned RS2_LSB = 3;

   function automatic logic op_is_legal(input logic [OPC_W-1:0] op);
      return op <= OP_LAST;
   endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// Register file: two combinational read ports with write-through bypass,
// one synchronous write port, r0 hardwired to zero.
module reg_file_2r1w
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT,
   parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [REG_AW-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [REG_AW-1:0] raddr_a_i,
   output logic [DATA_W-1:0] rdata_a_o,
   input  logic [REG_AW-1:0] raddr_b_i,
   output logic [DATA_W-1:0] rdata_b_o
);

   localparam int unsigned NumRegs = 1 << REG_AW;

   logic [DATA_W-1:0] mem_q [NumRegs];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NumRegs; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i && (waddr_i != '0)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_comb begin
      rdata_a_o = mem_q[raddr_a_i];
      if (raddr_a_i == '0) begin
         rdata_a_o = '0;
      end else if (we_i && (waddr_i == raddr_a_i)) begin
         rdata_a_o = wdata_i;
      end
   end

   always_comb begin
      rdata_b_o = mem_q[raddr_b_i];
      if (raddr_b_i == '0) begin
         rdata_b_o = '0;
      end else if (we_i && (waddr_i == raddr_b_i)) begin
         rdata_b_o = wdata_i;
      end
   end

endmodule

// File: rtl/operand_fetch.sv
// Issue stage ahead of the ALU: decodes instructions, tracks outstanding
// destinations in a scoreboard and holds the registered operand payload.
module operand_fetch
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT,
   parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [INSTR_W-1:0] instr,
   input  logic               wb_en,
   input  logic [REG_AW-1:0]  wb_rd,
   input  logic [DATA_W-1:0]  wb_data,
   output logic               issue_valid,
   input  logic               issue_ready,
   output logic [DATA_W-1:0]  Rs1,
   output logic [DATA_W-1:0]  Rs2,
   output logic [OPC_W-1:0]   Opcode,
   output logic [REG_AW-1:0]  issue_rd,
   output logic               illegal
);

   localparam int unsigned NumRegs = 1 << REG_AW;

   logic [OPC_W-1:0]  opc;
   logic [REG_AW-1:0] rd, rs1, rs2;
   logic              legal;
   logic              unused_instr_bits;

   assign opc   = instr[OPC_LSB +: OPC_W];
   assign rd    = instr[RD_LSB +: REG_AW];
   assign rs1   = instr[RS1_LSB +: REG_AW];
   assign rs2   = instr[RS2_LSB +: REG_AW];
   assign legal = op_is_legal(opc);
   assign unused_instr_bits = ^instr[RS2_LSB-1:0];

   logic [DATA_W-1:0] rdata_a, rdata_b;

   reg_file_2r1w #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_reg_file (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (wb_en),
      .waddr_i   (wb_rd),
      .wdata_i   (wb_data),
      .raddr_a_i (rs1),
      .rdata_a_o (rdata_a),
      .raddr_b_i (rs2),
      .rdata_b_o (rdata_b)
   );

   logic [NumRegs-1:0] pending_q, pending_d;
   logic [NumRegs-1:0] clr_vec, set_vec, pend_eff;
   logic               issue_valid_q, issue_valid_d;
   logic [DATA_W-1:0]  rs1_q, rs1_d, rs2_q, rs2_d;
   logic [OPC_W-1:0]   opc_q, opc_d;
   logic [REG_AW-1:0]  rd_q, rd_d;
   logic               illegal_q, illegal_d;
   logic               hazard, out_free, accept, issue_load;

   always_comb begin
      clr_vec = '0;
      if (wb_en) begin
         clr_vec[wb_rd] = 1'b1;
      end
      // A register retiring this cycle no longer blocks; r0 is never pending.
      pend_eff = pending_q & ~clr_vec;
      hazard   = legal && (pend_eff[rs1] || pend_eff[rs2] || pend_eff[rd]);

      out_free    = !issue_valid_q || issue_ready;
      instr_ready = out_free && !hazard;
      accept      = instr_valid && instr_ready;
      issue_load  = accept && legal;

      set_vec = '0;
      if (issue_load) begin
         set_vec[rd] = 1'b1;
      end
      // Set after clear so a same-cycle set and clear leaves the bit set.
      pending_d = (pend_eff | set_vec) & ~NumRegs'(1);

      issue_valid_d = issue_valid_q;
      rs1_d         = rs1_q;
      rs2_d         = rs2_q;
      opc_d         = opc_q;
      rd_d          = rd_q;
      if (issue_load) begin
         issue_valid_d = 1'b1;
         rs1_d         = rdata_a;
         rs2_d         = rdata_b;
         opc_d         = opc;
         rd_d          = rd;
      end else if (issue_ready) begin
         issue_valid_d = 1'b0;
      end
      illegal_d = accept && !legal;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q     <= '0;
         issue_valid_q <= 1'b0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         opc_q         <= '0;
         rd_q          <= '0;
         illegal_q     <= 1'b0;
      end else begin
         pending_q     <= pending_d;
         issue_valid_q <= issue_valid_d;
         rs1_q         <= rs1_d;
         rs2_q         <= rs2_d;
         opc_q         <= opc_d;
         rd_q          <= rd_d;
         illegal_q     <= illegal_d;
      end
   end

   assign issue_valid = issue_valid_q;
   assign Rs1         = rs1_q;
   assign Rs2         = rs2_q;
   assign Opcode      = opc_q;
   assign issue_rd    = rd_q;
   assign illegal     = illegal_q;

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Issue stage directly upstream of the 8-bit ALU. It accepts 16-bit instructions over a valid/ready handshake and holds the 8×8-bit register file. It tracks outstanding destination registers with a scoreboard and presents registered `Rs1`/`Rs2`/`Opcode` to the ALU. ALU results return through a writeback port with same-cycle bypass.

## Interface
- `DATA_W`, 8, operand/register width (must match ALU)
- `REG_AW`, 3, register address width (8 registers, r0 hardwired to zero)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `instr_valid`  in  1  upstream instruction valid
- `instr_ready`  out  1  instruction accepted on edge where valid&&ready
- `instr`  in  16  [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] ignored
- `wb_en`  in  1  writeback strobe from ALU result path
- `wb_rd`  in  3  writeback register
- `wb_data`  in  8  writeback value
- `issue_valid`  out  1  ALU operands valid
- `issue_ready`  in  1  downstream accepts on valid&&ready
- `Rs1`, `Rs2`  out  8  operands to ALU
- `Opcode`  out  4  ALU opcode
- `issue_rd`  out  3  destination carried alongside the operation
- `illegal`  out  1  one-cycle pulse: illegal opcode dropped

## Operation
- Legal opcodes are 0–9: ADD, SUB, AND, OR, XOR, SHL, SHR, NOT, MUL, DIV. Opcodes 10–15 are illegal.
- Register file: r0 reads 0, and writes to r0 are ignored. A `wb_en` write takes effect at the clock edge.
- Read bypass: if `wb_en` is high and `wb_rd == rsX != 0` in the same cycle, the operand takes `wb_data`.
- Scoreboard: one pending bit per register, r1–r7.
  - Set on issue-register load when rd≠0.
  - Cleared on `wb_en` for that register.
  - A simultaneous set and clear of the same register leaves it set.
- Hazard: raised when `pending[rs1]`, `pending[rs2]` or `pending[rd]` is set (rd/rs ≠ 0) and that register is not being cleared by `wb_en` this cycle. Illegal opcodes never raise a hazard.
- `out_free = !issue_valid || issue_ready`.
- `instr_ready = out_free && !hazard`. This is combinational on `instr`, so upstream must hold `instr` stable while `instr_valid` is high.
- On accept with a legal opcode:
  - Load `Rs1`/`Rs2`/`Opcode`/`issue_rd`, then set `issue_valid`.
  - NOT (7) still reads rs2; the ALU ignores it.
- On accept with an illegal opcode:
  - Assert `illegal` for one cycle.
  - Nothing issued, no pending bit set.
  - `issue_valid` clears if the old entry is taken the same cycle.
- While `issue_valid && !issue_ready`, the payload is held bit-stable.

## Timing
- Reset (async assert, sync deassert by the system):
  - Outputs: `issue_valid`, `illegal`, `Rs1`, `Rs2`, `Opcode`, `issue_rd` = 0.
  - Internal: all registers and all pending bits = 0.
  - `instr_ready` = 1 after reset, since out_free and no hazard.
  - Reset mid-operation discards the in-flight issue entry and the scoreboard.
- Latency: instruction accepted at edge N → `issue_valid` and payload visible from edge N onward (1 cycle).
- Throughput: 1 instruction/cycle when `issue_ready` is held high and no hazards occur.
- Writeback and a dependent read in the same cycle: no stall; the bypassed value is captured at that edge.
- Back-to-back writeback to the same register as a new issue's rd: the pending bit stays set for the new issue.

## Structure
- Shared package `alu_pkg`:
  - Opcode localparams `OP_ADD`…`OP_DIV`, and `OP_LAST = 9`.
  - Instruction field bit positions.
  - `DATA_W` / `REG_AW` defaults.
  - This package is also used by the ALU and its bench.
- Sub-module `reg_file_2r1w`:
  - 8×8-bit, two combinational read ports with write bypass, one synchronous write port.
  - r0 forced to zero, async-reset clear.
- The scoreboard, handshake and issue register stay in `operand_fetch`.

## Test plan
- Preload via wb: r1=0x0F, r2=0x01. Then instr ADD rd=3 rs1=1 rs2=2 → next cycle `issue_valid`=1, Rs1=0x0F, Rs2=0x01, Opcode=0000, issue_rd=3.
- Bypass: `wb_en` rd=1 data=0xAA in the same cycle as instr SUB rs1=1 → Rs1=0xAA, no stall.
- RAW hazard:
  - Issue rd=3, then instr AND rs1=3 → `instr_ready`=0.
  - Then `wb_en` rd=3 data=0x10 → `instr_ready`=1 that cycle, and Rs1=0x10 is issued next cycle.
- Backpressure: hold `issue_ready`=0 for 3 cycles with a second instr waiting → payload unchanged and `instr_ready`=0. On release, the second instr issues the following cycle.
- Illegal: instr opcode 1010 rd=4 → accepted, `illegal` pulses 1 cycle, `issue_valid` stays 0, and a later read of r4 does not stall.
- r0 and reset:
  - wb rd=0 data=0xFF, then read rs1=0 → Rs1=0x00.
  - Drop `rst_n` while `issue_valid`=1 → all outputs 0 immediately, and scoreboard clear after release.
